// File: rtl/cibus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cibus_arbiter
//  Purpose  : Packet-level arbiter sharing one CI bus (valid/busy/data/end)
//             among NUM_SRC requesters. A source owns the bus from its first
//             beat up to and including its end beat. Its beats pass through a
//             one-beat registered output stage that honours ci_busy.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_SRC  number of requesters (2..8)
//    DW       CI data width
//  Ports
//    s_clk       in   clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    src_valid   in   [NUM_SRC]     per-source beat valid
//    src_data    in   [NUM_SRC*DW]  per-source beat data, source i at [i*DW +: DW]
//    src_end     in   [NUM_SRC]     per-source last beat of packet
//    src_busy    out  [NUM_SRC]     per-source back-pressure
//    ci_valid    out  CI beat valid
//    ci_busy     in   CI back-pressure
//    ci_data     out  [DW] CI beat data
//    ci_end      out  CI last beat of packet
//    grant       out  [NUM_SRC] one-hot owner, zero while idle
//    arb_active  out  high while a source owns the bus
//  Build option
//    CIBUS_ARB_FIXED_PRIO_EN  when defined, the lowest-index requester always
//                             wins and no round-robin pointer exists.
//                             Otherwise arbitration is round-robin.
// ============================================================================
module cibus_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 128
) (
    input  logic                    s_clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*DW-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_end,
    output logic [NUM_SRC-1:0]      src_busy,
    output logic                    ci_valid,
    input  logic                    ci_busy,
    output logic [DW-1:0]           ci_data,
    output logic                    ci_end,
    output logic [NUM_SRC-1:0]      grant,
    output logic                    arb_active
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 ci_valid_q, ci_valid_d;
    logic                 ci_end_q, ci_end_d;
    logic [DW-1:0]        ci_data_q, ci_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]   w_win_oh;     // one-hot winner of this cycle's search
    logic                 w_win_found;  // at least one requester present
    logic                 w_out_stall;  // output register full and not draining
    logic [NUM_SRC-1:0]   w_accept_vec; // per-source beat acceptance
    logic                 w_accept;     // owner's beat accepted this cycle
    logic                 w_xfer;       // CI beat transferred this cycle
    logic [DW-1:0]        w_own_data;   // owner's beat data
    logic                 w_own_end;    // owner's end flag

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef CIBUS_ARB_FIXED_PRIO_EN

    // Lowest index wins; the found flag stops later sources overriding.
    always_comb begin
        w_win_found = 1'b0;
        w_win_oh    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_win_found && src_valid[i]) begin
                w_win_found = 1'b1;
                w_win_oh[i] = 1'b1;
            end
        end
    end

`else

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IW-1:0]  last_q, last_d;  // index of the last granted source
    logic [IW-1:0]  w_win_idx;
    logic [IW:0]    w_cand;          // one extra bit so last+k cannot overflow

    // Search last+1, last+2, ... wrapping modulo NUM_SRC. The sum never
    // reaches 2*NUM_SRC, so one conditional subtract implements the wrap
    // for non-power-of-two NUM_SRC as well.
    always_comb begin
        w_win_found = 1'b0;
        w_win_oh    = '0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = {1'b0, last_q} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(NUM_SRC)) begin
                w_cand = w_cand - (IW+1)'(NUM_SRC);
            end
            if (!w_win_found && src_valid[w_cand[IW-1:0]]) begin
                w_win_found              = 1'b1;
                w_win_idx                = w_cand[IW-1:0];
                w_win_oh[w_cand[IW-1:0]] = 1'b1;
            end
        end
    end

    // The pointer moves only when a grant is issued (IDLE -> GRANT).
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && w_win_found) begin
            last_d = w_win_idx;
        end
    end

    // Reset to NUM_SRC-1 so that source 0 is searched first.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(NUM_SRC - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // ------------------------------------------------------------------
    // Owner datapath
    // ------------------------------------------------------------------
    assign w_out_stall = ci_valid_q && ci_busy;
    assign w_xfer      = ci_valid_q && !ci_busy;

    // grant_q is zero in IDLE, so every source sees busy there without an
    // explicit state term; in GRANT only the owner can ever see busy low.
    assign src_busy     = ~grant_q | {NUM_SRC{w_out_stall}};
    assign w_accept_vec = src_valid & ~src_busy;
    assign w_accept     = |w_accept_vec;
    assign w_own_end    = |(src_end & grant_q);

    // grant_q is one-hot, so an AND-OR select picks the owner's data.
    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                w_own_data = w_own_data | src_data[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (w_win_found) begin
                    state_d = ST_GRANT;
                    grant_d = w_win_oh;
                end
            end
            ST_GRANT: begin
                // The end beat being accepted releases the bus; other
                // requesters are only considered once back in IDLE.
                if (w_accept && w_own_end) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // An accept is only possible when the register is empty or draining,
    // so loading on accept covers the back-to-back case with no bubble.
    always_comb begin
        ci_valid_d = ci_valid_q;
        ci_end_d   = ci_end_q;
        ci_data_d  = ci_data_q;
        if (w_accept) begin
            ci_valid_d = 1'b1;
            ci_end_d   = w_own_end;
            ci_data_d  = w_own_data;
        end else if (w_xfer) begin
            // Data is left as-is; it is meaningless while valid is low.
            ci_valid_d = 1'b0;
            ci_end_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ci_valid_q <= 1'b0;
            ci_end_q   <= 1'b0;
            ci_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ci_valid_q <= ci_valid_d;
            ci_end_q   <= ci_end_d;
            ci_data_q  <= ci_data_d;
        end
    end

    assign ci_valid   = ci_valid_q;
    assign ci_end     = ci_end_q;
    assign ci_data    = ci_data_q;
    assign grant      = grant_q;
    assign arb_active = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_cibus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cibus_arbiter
//  Purpose  : Self-checking bench for cibus_arbiter (NUM_SRC=4, DW=128).
//             Source beats come from per-source queues; expected CI beats are
//             queued in bus order and compared as the CI side transfers them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cibus_arbiter;

    localparam int NS = 4;
    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } beat_t;

    logic               s_clk;
    logic               rst_n;
    logic [NS-1:0]      src_valid;
    logic [NS*DW-1:0]   src_data;
    logic [NS-1:0]      src_end;
    logic [NS-1:0]      src_busy;
    logic               ci_valid;
    logic               ci_busy;
    logic [DW-1:0]      ci_data;
    logic               ci_end;
    logic [NS-1:0]      grant;
    logic               arb_active;

    int    total;
    int    bad;
    beat_t srcq [NS][$];
    beat_t expq [$];

    cibus_arbiter #(
        .NUM_SRC (NS),
        .DW      (DW)
    ) dut (
        .s_clk      (s_clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_end    (src_end),
        .src_busy   (src_busy),
        .ci_valid   (ci_valid),
        .ci_busy    (ci_busy),
        .ci_data    (ci_data),
        .ci_end     (ci_end),
        .grant      (grant),
        .arb_active (arb_active)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    function automatic logic [DW-1:0] mkdata(input int s, input int p, input int b);
        logic [31:0] w;
        w = 32'h0000_00C3 | (32'(s) << 24) | (32'(p) << 16) | (32'(b) << 8);
        return {4{w}};
    endfunction

    // Checks happen 2 time units after the rising edge; source inputs
    // change 1 time unit after it.
    task automatic tick();
        @(posedge s_clk);
        #2;
    endtask

    task automatic queue_src(input int s, input int p, input int n);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.d = mkdata(s, p, b);
            bt.e = (b == n - 1);
            srcq[s].push_back(bt);
        end
    endtask

    // Pushes the first 'upto' beats of an n-beat packet as expected CI beats.
    task automatic expect_pkt(input int s, input int p, input int n, input int upto);
        beat_t bt;
        for (int b = 0; b < upto; b++) begin
            bt.d = mkdata(s, p, b);
            bt.e = (b == n - 1);
            expq.push_back(bt);
        end
    endtask

    task automatic drain(output logic ok);
        logic empty;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            empty = (expq.size() == 0) && !ci_valid;
            for (int i = 0; i < NS; i++) begin
                if (srcq[i].size() != 0) empty = 1'b0;
            end
            if (empty) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Source driver: sample the handshake at the edge, then present the
    // head of each source queue.
    // ------------------------------------------------------------------
    initial begin
        logic [NS-1:0] acc;
        beat_t         tmp;
        src_valid = '0;
        src_data  = '0;
        src_end   = '0;
        forever begin
            @(posedge s_clk);
            acc = src_valid & ~src_busy;
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && srcq[i].size() != 0) tmp = srcq[i].pop_front();
                if (srcq[i].size() != 0) begin
                    src_valid[i]          = 1'b1;
                    src_data[i*DW +: DW]  = srcq[i][0].d;
                    src_end[i]            = srcq[i][0].e;
                end else begin
                    src_valid[i] = 1'b0;
                    src_end[i]   = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: every CI transfer must match the next expected beat.
    // ------------------------------------------------------------------
    always @(posedge s_clk) begin
        beat_t e;
        if (rst_n && ci_valid && !ci_busy) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL sb_extra_beat: got data=%h end=%b, required no beat", ci_data, ci_end);
            end else begin
                e = expq.pop_front();
                if (ci_data !== e.d || ci_end !== e.e) begin
                    bad++;
                    $display("FAIL sb_beat: got data=%h end=%b, required data=%h end=%b",
                             ci_data, ci_end, e.d, e.e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n   = 1'b0;
        ci_busy = 1'b0;
        tick();
        tick();
        total++;
        if ({ci_valid, ci_end, arb_active} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got valid/end/active=%b, required 000", {ci_valid, ci_end, arb_active});
        end
        total++;
        if (ci_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h, required 0", ci_data);
        end
        total++;
        if (grant !== 4'b0000 || src_busy !== 4'b1111) begin
            bad++;
            $display("FAIL reset_grant_busy: got grant=%b busy=%b, required 0000/1111", grant, src_busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // All four sources hold two one-beat packets each from the same cycle.
    task automatic test_round_robin();
        int            exp_idx [8];
        int            pc [NS];
        int            gcnt;
        int            idle;
        logic          seen;
        logic          ok;
        logic [NS-1:0] prev;
        for (int i = 0; i < NS; i++) pc[i] = 0;
        for (int k = 0; k < 8; k++) begin
`ifdef CIBUS_ARB_FIXED_PRIO_EN
            exp_idx[k] = k / 2;
`else
            exp_idx[k] = k % 4;
`endif
        end
        for (int s = 0; s < NS; s++) begin
            queue_src(s, 0, 1);
            queue_src(s, 1, 1);
        end
        for (int k = 0; k < 8; k++) begin
            expect_pkt(exp_idx[k], pc[exp_idx[k]], 1, 1);
            pc[exp_idx[k]]++;
        end
        gcnt = 0;
        idle = 0;
        seen = 1'b0;
        prev = '0;
        for (int c = 0; c < 80 && gcnt < 8; c++) begin
            tick();
            if (grant !== '0) begin
                if (grant !== prev) begin
                    if (seen) begin
                        total++;
                        if (idle != 1) begin
                            bad++;
                            $display("FAIL rr_gap: got %0d idle cycles before grant %0d, required 1", idle, gcnt);
                        end
                    end
                    total++;
                    if (grant !== 4'(1 << exp_idx[gcnt])) begin
                        bad++;
                        $display("FAIL rr_order: grant %0d got %b, required %b", gcnt, grant, 4'(1 << exp_idx[gcnt]));
                    end
                    gcnt++;
                    seen = 1'b1;
                end
                idle = 0;
            end else begin
                idle++;
            end
            prev = grant;
        end
        total++;
        if (gcnt != 8) begin
            bad++;
            $display("FAIL rr_timeout: got %0d grants, required 8", gcnt);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rr_drain: got %0d beats outstanding, required 0", expq.size());
        end
    endtask

    task automatic test_single_packet();
        logic found;
        logic ok;
        queue_src(1, 0, 3);
        expect_pkt(1, 0, 3, 3);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (src_valid[1]) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || grant !== 4'b0000 || src_busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL sp_request: got found=%b grant=%b busy=%b, required 1/0000/1", found, grant, src_busy[1]);
        end
        tick();
        total++;
        if (grant !== 4'b0010 || arb_active !== 1'b1 || ci_valid !== 1'b0 || src_busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL sp_grant: got grant=%b active=%b valid=%b busy=%b, required 0010/1/0/0",
                     grant, arb_active, ci_valid, src_busy[1]);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            total++;
            if (ci_valid !== 1'b1 || ci_data !== mkdata(1, 0, b) || ci_end !== (b == 2)) begin
                bad++;
                $display("FAIL sp_beat%0d: got valid=%b end=%b data=%h, required 1/%b/%h",
                         b, ci_valid, ci_end, ci_data, (b == 2), mkdata(1, 0, b));
            end
        end
        total++;
        if (grant !== 4'b0000 || arb_active !== 1'b0) begin
            bad++;
            $display("FAIL sp_release: got grant=%b active=%b, required 0000/0", grant, arb_active);
        end
        tick();
        total++;
        if (ci_valid !== 1'b0 || ci_end !== 1'b0) begin
            bad++;
            $display("FAIL sp_idle: got valid=%b end=%b, required 0/0", ci_valid, ci_end);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sp_drain: got %0d beats outstanding, required 0", expq.size());
        end
    endtask

    task automatic test_back_pressure();
        logic found;
        logic ok;
        queue_src(2, 0, 4);
        expect_pkt(2, 0, 4, 4);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ci_valid && ci_data === mkdata(2, 0, 1)) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL bp_wait: got no D1 on bus, required D1 within 20 cycles");
        end
        ci_busy = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (ci_valid !== 1'b1 || ci_data !== mkdata(2, 0, 1) || ci_end !== 1'b0 || src_busy[2] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b end=%b busy=%b data=%h, required 1/0/1/%h",
                         k, ci_valid, ci_end, src_busy[2], ci_data, mkdata(2, 0, 1));
            end
            if (k < 4) tick();
        end
        ci_busy = 1'b0;
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_drain: got %0d beats outstanding, required 0", expq.size());
        end
    endtask

    task automatic test_contention();
        logic found;
        logic ok;
        queue_src(0, 1, 4);
        expect_pkt(0, 1, 4, 4);
        expect_pkt(2, 1, 2, 2);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant === 4'b0001) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL ct_grant0: got grant=%b, required 0001", grant);
        end
        queue_src(2, 1, 2);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (src_busy[2] !== 1'b1) begin
                bad++;
                $display("FAIL ct_busy2: got src_busy[2]=%b, required 1", src_busy[2]);
            end
            if (src_valid[0] && src_end[0] && !src_busy[0]) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL ct_end_wait: got no end-beat acceptance, required one within 20 cycles");
        end
        tick();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL ct_idle: got grant=%b, required 0000", grant);
        end
        tick();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL ct_grant2: got grant=%b, required 0100", grant);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ct_drain: got %0d beats outstanding, required 0", expq.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        logic          found;
        logic          ok;
        logic [NS-1:0] first;
        queue_src(1, 2, 4);
        expect_pkt(1, 2, 4, 2);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ci_valid && ci_data === mkdata(1, 2, 1)) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rm_wait: got no beat 2 on bus, required it within 20 cycles");
        end
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (ci_valid !== 1'b0 || ci_end !== 1'b0 || grant !== 4'b0000 || src_busy !== 4'b1111 || arb_active !== 1'b0) begin
            bad++;
            $display("FAIL rm_clear: got valid=%b end=%b grant=%b busy=%b active=%b, required 0/0/0000/1111/0",
                     ci_valid, ci_end, grant, src_busy, arb_active);
        end
        srcq[1].delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // Sources 0 and 3 request together: with the pointer back at
        // NUM_SRC-1 the search starts at 0 in both builds.
        queue_src(3, 3, 2);
        queue_src(0, 3, 1);
        expect_pkt(0, 3, 1, 1);
        expect_pkt(3, 3, 2, 2);
        first = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant !== '0) begin
                first = grant;
                break;
            end
        end
        total++;
        if (first !== 4'b0001) begin
            bad++;
            $display("FAIL rm_first: got grant=%b, required 0001", first);
        end
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant !== '0 && grant !== 4'b0001) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || grant !== 4'b1000) begin
            bad++;
            $display("FAIL rm_src3: got grant=%b, required 1000", grant);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rm_drain: got %0d beats outstanding, required 0", expq.size());
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        ci_busy = 1'b0;
        test_reset();
        test_round_robin();
        test_single_packet();
        test_back_pressure();
        test_contention();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cibus_arbiter.md
# cibus_arbiter

Packet-level arbiter that shares one CI bus (valid/busy/128-bit data/end) among `NUM_SRC` requesters. It sits between the upstream packet sources and the single CI bus master port. It grants one source at a time for a whole packet, from first beat through the `ci_end` beat. It forwards that source's beats through a one-beat registered output stage, honouring `ci_busy` back-pressure.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, legal 2..8.
- `DW`, 128: CI data width; must equal the CI bus `ci_data` width.

Ports:
- `s_clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  `NUM_SRC`  per-source beat valid.
- `src_data`  in  `NUM_SRC*DW`  per-source beat data; source i occupies `[i*DW +: DW]`.
- `src_end`  in  `NUM_SRC`  per-source last-beat-of-packet flag, qualified by `src_valid`.
- `src_busy`  out  `NUM_SRC`  per-source back-pressure; beat accepted when `src_valid[i] && !src_busy[i]`.
- `ci_valid`  out  1  CI beat valid.
- `ci_busy`  in  1  CI back-pressure; beat transferred when `ci_valid && !ci_busy`.
- `ci_data`  out  `DW`  CI beat data.
- `ci_end`  out  1  CI last beat of packet.
- `grant`  out  `NUM_SRC`  one-hot current owner; all-zero in IDLE.
- `arb_active`  out  1  high in GRANT state.

## Operation
FSM has two states:
- **IDLE**
  - `grant`=0 and all `src_busy`=1.
  - If any `src_valid` is set, select the winner and go to GRANT next cycle with `grant` one-hot registered.
- **GRANT**, owner g:
  - `src_busy[g] = ci_valid && ci_busy`, i.e. the output register is full and not draining. Every other `src_busy` is 1.
  - An accepted beat loads the output register: `ci_data`←`src_data[g]`, `ci_end`←`src_end[g]`, `ci_valid`←1.
  - Acceptance of a beat with `src_end[g]`=1 returns the FSM to IDLE next cycle.

Output register:
- Holds its value while `ci_valid && ci_busy`.
- Clears `ci_valid` (and `ci_end`) after a transfer when no new beat is accepted in the same cycle.
- A transfer and an accept in the same cycle replace the contents with no bubble.
- `ci_data` is don't-care when `ci_valid`=0; the implementation holds the last value.

Arbitration (default round-robin):
- Pointer `last` holds the index of the last granted source; reset value `NUM_SRC-1`, so source 0 is favoured first.
- Search order is `last+1`, `last+2`, … modulo `NUM_SRC`; the first set `src_valid` wins.
- `last` updates on entry to GRANT.

Boundary conditions:
- A `src_valid` raised by a non-owner mid-packet waits. It is evaluated only in IDLE.
- A single-beat packet (`src_valid` and `src_end` on the first beat) is legal.
- The owner may drop `src_valid` mid-packet. The grant holds indefinitely; there is no timeout.
- Sources keep `src_data`/`src_end` stable while `src_valid && src_busy`.
- Reset mid-packet:
  - All state clears immediately.
  - The packet is truncated; no `ci_end` is emitted. Recovery is the sink's responsibility.

Reset values: `ci_valid`=0, `ci_end`=0, `ci_data`=0, `grant`=0, `arb_active`=0, `src_busy`=all ones, state IDLE, `last`=`NUM_SRC-1`.

## Timing
- Request `src_valid` in IDLE at cycle n → `grant` at n+1 → beat accepted at end of n+1 → `ci_valid` at n+2. Request-to-CI latency is 2 cycles.
- Source-to-CI latency within a packet is 1 cycle.
- Throughput is 1 beat/cycle while `ci_busy`=0.
- End beat accepted at cycle k:
  - IDLE at k+1.
  - Next grant at k+2.
  - Exactly one bubble cycle on the source side between packets. The CI side also loses one beat slot.
- `src_busy` is combinational from `ci_busy`, `ci_valid` and state.

## Configuration
- `CIBUS_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `last` is not implemented.
- Undefined (default): round-robin as above.
- No other behaviour differs between the two builds.

## Test plan
- **Single packet:** source 1 sends 3 beats D0..D2 with `src_end` on D2, `ci_busy`=0.
  - `grant`=0010.
  - `ci_valid` high for 3 consecutive cycles starting 2 cycles after the request, carrying D0, D1, D2.
  - `ci_end` only with D2; `grant`=0 the cycle after D2 is accepted.
- **Round-robin:** all 4 sources continuously request 1-beat packets. Grant order is 0,1,2,3,0,1 with one IDLE cycle between grants. Under `CIBUS_ARB_FIXED_PRIO_EN` the order is always 0.
- **Back-pressure:** `ci_busy`=1 for 5 cycles while beat D1 of a 4-beat packet is on the bus.
  - `ci_data`=D1 stable for all 5 cycles; `src_busy[g]`=1 throughout.
  - No beat lost or duplicated; `ci_end` appears only on D3.
- **Contention:** source 2 requests while source 0's 4-beat packet is in flight.
  - `src_busy[2]`=1 until source 0's end beat is accepted.
  - Source 2 is granted 2 cycles after that acceptance; packets are not interleaved on CI.
- **Reset mid-packet:** assert `rst_n`=0 after beat 2 of 4.
  - `ci_valid`, `ci_end` and `grant` go to 0 and `src_busy` to all ones immediately.
  - After release, a new request from source 3 is served with the pointer back at its reset value.
